clk_edge_monitor: RTL and testbench



---
 rtl/clk_edge_monitor_if.sv | 28 ++
 rtl/clk_edge_monitor.sv | 131 +++++++++++++
 tb/tb_clk_edge_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/clk_edge_monitor_if.sv
// Signal bundle between a slow-clock source/consumer and clk_edge_monitor.
// The monitor attaches through the slave modport.
interface clk_edge_monitor_if #(
  parameter int unsigned CNT_W = 32
);
  logic             slow_in;
  logic             clear;
  logic             edge_tick;
  logic             rise_tick;
  logic [CNT_W-1:0] half_period;
  logic             period_valid;
  logic             stalled;
  logic [15:0]      edge_count;
  logic [CNT_W-1:0] min_half;
  logic [CNT_W-1:0] max_half;

  modport master (
    output slow_in, clear,
    input  edge_tick, rise_tick, half_period, period_valid, stalled,
           edge_count, min_half, max_half
  );

  modport slave (
    input  slow_in, clear,
    output edge_tick, rise_tick, half_period, period_valid, stalled,
           edge_count, min_half, max_half
  );
endinterface

// File: rtl/clk_edge_monitor.sv
// Synchronizes a slow toggle, emits edge ticks, measures edge-to-edge intervals and flags stalls.
// Define CLK_MON_MINMAX_EN to build the min/max interval trackers.
module clk_edge_monitor #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1_000_000_000
) (
  input  logic               clock,
  input  logic               reset,
  clk_edge_monitor_if.slave  mon
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    STALLED    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             s1, s2, s3;
  logic             edge_det;
  logic             rise_det;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_nxt;
  logic             valid_nxt;
  logic             stalled_nxt;

  // Three-flop synchronizer plus one registered detect stage; clear drops an in-flight edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      edge_det <= 1'b0;
      rise_det <= 1'b0;
    end else begin
      s1       <= mon.slow_in;
      s2       <= s1;
      s3       <= s2;
      edge_det <= ~mon.clear & (s2 ^ s3);
      rise_det <= ~mon.clear & s2 & ~s3;
    end
  end

  // Next-state and measurement decode; an edge always beats the timeout.
  always_comb begin
    state_nxt = state;
    half_nxt  = mon.half_period;
    valid_nxt = mon.period_valid;
    case (state)
      WAIT_FIRST: begin
        if (edge_det) begin
          state_nxt = MEASURE;
        end else if (cnt == LIMIT) begin
          state_nxt = STALLED;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          half_nxt  = cnt;
          valid_nxt = 1'b1;
        end else if (cnt == LIMIT) begin
          state_nxt = STALLED;
          valid_nxt = 1'b0;
        end
      end
      STALLED: begin
        if (edge_det) begin
          state_nxt = MEASURE;
        end
      end
      default: begin
        state_nxt = WAIT_FIRST;
      end
    endcase
    stalled_nxt = (state_nxt == STALLED);
  end

  always_ff @(posedge clock) begin
    if (reset || mon.clear) begin
      state            <= WAIT_FIRST;
      cnt              <= '0;
      mon.half_period  <= '0;
      mon.period_valid <= 1'b0;
      mon.stalled      <= 1'b0;
      mon.edge_tick    <= 1'b0;
      mon.rise_tick    <= 1'b0;
      mon.edge_count   <= 16'd0;
    end else begin
      state            <= state_nxt;
      mon.half_period  <= half_nxt;
      mon.period_valid <= valid_nxt;
      mon.stalled      <= stalled_nxt;
      mon.edge_tick    <= edge_det;
      mon.rise_tick    <= rise_det;
      if (edge_det) begin
        cnt            <= ONE;
        mon.edge_count <= mon.edge_count + 16'd1;
      end else if (cnt != LIMIT) begin
        cnt <= cnt + ONE;
      end
    end
  end

`ifdef CLK_MON_MINMAX_EN
  logic record;
  assign record = edge_det && (state == MEASURE);

  // Extrema follow every recorded measurement.
  always_ff @(posedge clock) begin
    if (reset || mon.clear) begin
      mon.min_half <= '1;
      mon.max_half <= '0;
    end else if (record) begin
      if (cnt < mon.min_half) begin
        mon.min_half <= cnt;
      end
      if (cnt > mon.max_half) begin
        mon.max_half <= cnt;
      end
    end
  end
`else
  assign mon.min_half = '0;
  assign mon.max_half = '0;
`endif

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Directed self-checking bench for clk_edge_monitor (CNT_W=16, TIMEOUT=100).
// Tick latency is four clock edges from the cycle slow_in is driven.
module tb_clk_edge_monitor;

  localparam int unsigned CNT_W = 16;

`ifdef CLK_MON_MINMAX_EN
  localparam logic [CNT_W-1:0] MIN_RST = 16'hFFFF;
`else
  localparam logic [CNT_W-1:0] MIN_RST = 16'h0000;
`endif

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  clk_edge_monitor_if #(.CNT_W(CNT_W)) bus ();

  clk_edge_monitor #(
    .CNT_W   (CNT_W),
    .TIMEOUT (100)
  ) dut (
    .clock (clock),
    .reset (reset),
    .mon   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Toggle slow_in so the resulting tick lands n cycles after the current cycle.
  task automatic edge_after(input int n);
    tick(n - 4);
    bus.slow_in = ~bus.slow_in;
    tick(4);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.slow_in = 1'b1;
    bus.clear = 1'b0;
    tick(2);
    n_checks++; if (bus.edge_tick !== 1'b0) begin n_fail++; $display("FAIL rst_edge_tick got %0d exp 0", bus.edge_tick); end
    n_checks++; if (bus.edge_count !== 16'd0) begin n_fail++; $display("FAIL rst_edge_count got %0d exp 0", bus.edge_count); end
    n_checks++; if (bus.half_period !== 16'd0) begin n_fail++; $display("FAIL rst_half got %0d exp 0", bus.half_period); end
    n_checks++; if (bus.period_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0d exp 0", bus.period_valid); end
    n_checks++; if (bus.stalled !== 1'b0) begin n_fail++; $display("FAIL rst_stalled got %0d exp 0", bus.stalled); end
    n_checks++; if (bus.min_half !== MIN_RST) begin n_fail++; $display("FAIL rst_min got %0h exp %0h", bus.min_half, MIN_RST); end
    n_checks++; if (bus.max_half !== 16'd0) begin n_fail++; $display("FAIL rst_max got %0h exp 0", bus.max_half); end
    reset = 1'b0;
    tick(3);
    n_checks++; if (bus.edge_tick !== 1'b0) begin n_fail++; $display("FAIL rel_early_tick got %0d exp 0", bus.edge_tick); end
    tick(1);
    n_checks++; if (bus.edge_tick !== 1'b1) begin n_fail++; $display("FAIL rel_edge_tick got %0d exp 1", bus.edge_tick); end
    n_checks++; if (bus.rise_tick !== 1'b1) begin n_fail++; $display("FAIL rel_rise_tick got %0d exp 1", bus.rise_tick); end
    n_checks++; if (bus.edge_count !== 16'd1) begin n_fail++; $display("FAIL rel_edge_count got %0d exp 1", bus.edge_count); end
    n_checks++; if (bus.period_valid !== 1'b0) begin n_fail++; $display("FAIL rel_valid got %0d exp 0", bus.period_valid); end
  endtask

  task automatic test_steady_toggle;
    edge_after(20);
    n_checks++; if (bus.edge_tick !== 1'b1) begin n_fail++; $display("FAIL tog1_edge got %0d exp 1", bus.edge_tick); end
    n_checks++; if (bus.rise_tick !== 1'b0) begin n_fail++; $display("FAIL tog1_rise got %0d exp 0", bus.rise_tick); end
    n_checks++; if (bus.half_period !== 16'd20) begin n_fail++; $display("FAIL tog1_half got %0d exp 20", bus.half_period); end
    n_checks++; if (bus.period_valid !== 1'b1) begin n_fail++; $display("FAIL tog1_valid got %0d exp 1", bus.period_valid); end
    n_checks++; if (bus.edge_count !== 16'd2) begin n_fail++; $display("FAIL tog1_count got %0d exp 2", bus.edge_count); end
    tick(1);
    n_checks++; if (bus.edge_tick !== 1'b0) begin n_fail++; $display("FAIL tog_pulse_width got %0d exp 0", bus.edge_tick); end
    edge_after(19);
    n_checks++; if (bus.rise_tick !== 1'b1) begin n_fail++; $display("FAIL tog2_rise got %0d exp 1", bus.rise_tick); end
    n_checks++; if (bus.half_period !== 16'd20) begin n_fail++; $display("FAIL tog2_half got %0d exp 20", bus.half_period); end
    n_checks++; if (bus.edge_count !== 16'd3) begin n_fail++; $display("FAIL tog2_count got %0d exp 3", bus.edge_count); end
    edge_after(20);
    n_checks++; if (bus.rise_tick !== 1'b0) begin n_fail++; $display("FAIL tog3_rise got %0d exp 0", bus.rise_tick); end
    n_checks++; if (bus.edge_count !== 16'd4) begin n_fail++; $display("FAIL tog3_count got %0d exp 4", bus.edge_count); end
  endtask

  task automatic test_stall;
    tick(99);
    n_checks++; if (bus.stalled !== 1'b0) begin n_fail++; $display("FAIL stall_early got %0d exp 0", bus.stalled); end
    n_checks++; if (bus.period_valid !== 1'b1) begin n_fail++; $display("FAIL stall_early_valid got %0d exp 1", bus.period_valid); end
    tick(1);
    n_checks++; if (bus.stalled !== 1'b1) begin n_fail++; $display("FAIL stall_set got %0d exp 1", bus.stalled); end
    n_checks++; if (bus.period_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid got %0d exp 0", bus.period_valid); end
    n_checks++; if (bus.half_period !== 16'd20) begin n_fail++; $display("FAIL stall_half_held got %0d exp 20", bus.half_period); end
    edge_after(50);
    n_checks++; if (bus.edge_tick !== 1'b1) begin n_fail++; $display("FAIL recov_edge got %0d exp 1", bus.edge_tick); end
    n_checks++; if (bus.stalled !== 1'b0) begin n_fail++; $display("FAIL recov_stalled got %0d exp 0", bus.stalled); end
    n_checks++; if (bus.half_period !== 16'd20) begin n_fail++; $display("FAIL recov_half got %0d exp 20", bus.half_period); end
    n_checks++; if (bus.period_valid !== 1'b0) begin n_fail++; $display("FAIL recov_valid got %0d exp 0", bus.period_valid); end
    n_checks++; if (bus.edge_count !== 16'd5) begin n_fail++; $display("FAIL recov_count got %0d exp 5", bus.edge_count); end
    edge_after(30);
    n_checks++; if (bus.half_period !== 16'd30) begin n_fail++; $display("FAIL recov2_half got %0d exp 30", bus.half_period); end
    n_checks++; if (bus.period_valid !== 1'b1) begin n_fail++; $display("FAIL recov2_valid got %0d exp 1", bus.period_valid); end
  endtask

  task automatic test_timeout_boundary;
    tick(96);
    bus.slow_in = ~bus.slow_in;
    tick(3);
    n_checks++; if (bus.stalled !== 1'b0) begin n_fail++; $display("FAIL bnd_pre_stalled got %0d exp 0", bus.stalled); end
    tick(1);
    n_checks++; if (bus.edge_tick !== 1'b1) begin n_fail++; $display("FAIL bnd_edge got %0d exp 1", bus.edge_tick); end
    n_checks++; if (bus.half_period !== 16'd100) begin n_fail++; $display("FAIL bnd_half got %0d exp 100", bus.half_period); end
    n_checks++; if (bus.stalled !== 1'b0) begin n_fail++; $display("FAIL bnd_stalled got %0d exp 0", bus.stalled); end
    n_checks++; if (bus.edge_count !== 16'd7) begin n_fail++; $display("FAIL bnd_count got %0d exp 7", bus.edge_count); end
    tick(1);
    n_checks++; if (bus.stalled !== 1'b0) begin n_fail++; $display("FAIL bnd_post_stalled got %0d exp 0", bus.stalled); end
  endtask

  task automatic test_clear_and_extrema;
    tick(10);
    bus.slow_in = ~bus.slow_in;
    tick(3);
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    n_checks++; if (bus.edge_tick !== 1'b0) begin n_fail++; $display("FAIL clr_edge got %0d exp 0", bus.edge_tick); end
    n_checks++; if (bus.edge_count !== 16'd0) begin n_fail++; $display("FAIL clr_count got %0d exp 0", bus.edge_count); end
    n_checks++; if (bus.half_period !== 16'd0) begin n_fail++; $display("FAIL clr_half got %0d exp 0", bus.half_period); end
    n_checks++; if (bus.period_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %0d exp 0", bus.period_valid); end
    n_checks++; if (bus.min_half !== MIN_RST) begin n_fail++; $display("FAIL clr_min got %0h exp %0h", bus.min_half, MIN_RST); end
    tick(1);
    n_checks++; if (bus.edge_tick !== 1'b0) begin n_fail++; $display("FAIL clr_late_edge got %0d exp 0", bus.edge_tick); end
    edge_after(20);
    n_checks++; if (bus.edge_count !== 16'd1) begin n_fail++; $display("FAIL wf_count got %0d exp 1", bus.edge_count); end
    n_checks++; if (bus.period_valid !== 1'b0) begin n_fail++; $display("FAIL wf_valid got %0d exp 0", bus.period_valid); end
    n_checks++; if (bus.half_period !== 16'd0) begin n_fail++; $display("FAIL wf_half got %0d exp 0", bus.half_period); end
    edge_after(20);
    n_checks++; if (bus.half_period !== 16'd20) begin n_fail++; $display("FAIL ext1_half got %0d exp 20", bus.half_period); end
    edge_after(35);
    n_checks++; if (bus.half_period !== 16'd35) begin n_fail++; $display("FAIL ext2_half got %0d exp 35", bus.half_period); end
    edge_after(12);
    n_checks++; if (bus.half_period !== 16'd12) begin n_fail++; $display("FAIL ext3_half got %0d exp 12", bus.half_period); end
    n_checks++; if (bus.edge_count !== 16'd4) begin n_fail++; $display("FAIL ext_count got %0d exp 4", bus.edge_count); end
`ifdef CLK_MON_MINMAX_EN
    n_checks++; if (bus.min_half !== 16'd12) begin n_fail++; $display("FAIL ext_min got %0d exp 12", bus.min_half); end
    n_checks++; if (bus.max_half !== 16'd35) begin n_fail++; $display("FAIL ext_max got %0d exp 35", bus.max_half); end
`else
    n_checks++; if (bus.min_half !== 16'd0) begin n_fail++; $display("FAIL ext_min got %0d exp 0", bus.min_half); end
    n_checks++; if (bus.max_half !== 16'd0) begin n_fail++; $display("FAIL ext_max got %0d exp 0", bus.max_half); end
`endif
  endtask

  task automatic test_reset_mid;
    bus.slow_in = ~bus.slow_in;
    tick(3);
    reset = 1'b1;
    tick(1);
    n_checks++; if (bus.edge_tick !== 1'b0) begin n_fail++; $display("FAIL mid_edge got %0d exp 0", bus.edge_tick); end
    n_checks++; if (bus.edge_count !== 16'd0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", bus.edge_count); end
    n_checks++; if (bus.half_period !== 16'd0) begin n_fail++; $display("FAIL mid_half got %0d exp 0", bus.half_period); end
    n_checks++; if (bus.period_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %0d exp 0", bus.period_valid); end
    n_checks++; if (bus.max_half !== 16'd0) begin n_fail++; $display("FAIL mid_max got %0d exp 0", bus.max_half); end
    tick(1);
    n_checks++; if (bus.edge_tick !== 1'b0) begin n_fail++; $display("FAIL mid_late_edge got %0d exp 0", bus.edge_tick); end
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_steady_toggle();
    test_stall();
    test_timeout_boundary();
    test_clear_and_extrema();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
